dcache_load_responder: RTL and testbench

Load-side responder of the data cache: serves the `LQ_DCACHE_PACKET` requests issued by the load queue, answering hits in the same cycle and tracking misses in a small MSHR file. On memory return it installs the block and broadcasts `DCACHE_LQ_PACKET` completions (`lq_idx` plus aligned word) back to the load queue. It sits between the load queue and the memory bus and is read-only with respect to memory.

---
 rtl/dcache_load_responder.sv | 171 +++++++++++++++++
 tb/tb_dcache_load_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dcache_load_responder.sv
// dcache_load_responder: load-side data cache with same-cycle hits, MSHR miss tracking and registered completion drain
package dcache_load_responder_pkg;
  localparam int LQ_SIZE = 8;
  localparam int LQ_IDX_W = $clog2(LQ_SIZE);
  typedef logic [31:0] ADDR;
  typedef logic [31:0] DATA;
  typedef enum logic [1:0] {MEM_NONE = 2'h0, MEM_LOAD = 2'h1, MEM_STORE = 2'h2} MEM_COMMAND;
  typedef struct packed {
    logic valid;
    logic [LQ_IDX_W-1:0] lq_idx;
    ADDR addr;
    logic [2:0] mem_func;
  } LQ_DCACHE_PACKET;
  typedef struct packed {
    logic valid;
    logic [LQ_IDX_W-1:0] lq_idx;
    DATA data;
  } DCACHE_LQ_PACKET;
endpackage

module dcache_load_responder
  import dcache_load_responder_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int NUM_MSHR = 4,
  parameter int NUM_LU_DCACHE = 2,
  parameter int N = 2
) (
  input  logic clock,
  input  logic reset,
  input  LQ_DCACHE_PACKET lq_dcache_packet [NUM_LU_DCACHE],
  output logic [NUM_LU_DCACHE-1:0] load_req_accept,
  output logic [NUM_LU_DCACHE-1:0] load_req_data_valid,
  output DATA load_req_data [NUM_LU_DCACHE],
  output DCACHE_LQ_PACKET dcache_lq_packet [N],
  output MEM_COMMAND proc2mem_command,
  output ADDR proc2mem_addr,
  input  logic [3:0] mem2proc_transaction_tag,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0] mem2proc_data_tag
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 29 - IW;
  localparam int MW = $clog2(NUM_MSHR);
  typedef enum logic [1:0] {FREE, WAIT, DONE} mshr_state_e;
  logic [NUM_LINES-1:0] line_v;
  logic [TW-1:0] line_tag [NUM_LINES];
  logic [63:0] line_data [NUM_LINES];
  mshr_state_e st [NUM_MSHR];
  mshr_state_e st_nxt [NUM_MSHR];
  logic [3:0] mtag [NUM_MSHR];
  logic [28:0] mblk [NUM_MSHR];
  logic [63:0] mdata [NUM_MSHR];
  logic [LQ_SIZE-1:0] wait_mask [NUM_MSHR];
  logic [LQ_SIZE-1:0] set_mask [NUM_MSHR];
  logic [LQ_SIZE-1:0] clr [NUM_MSHR];
  logic [LQ_SIZE-1:0] mask_nxt [NUM_MSHR];
  logic [LQ_SIZE-1:0] wait_hi, hi_nxt;
  logic [NUM_MSHR-1:0] fill;
  logic free_any, tried, alloc, matched;
  logic [MW-1:0] free_idx;
  logic [28:0] alloc_blk;
  logic [IW-1:0] hidx;
  LQ_DCACHE_PACKET req;
  DCACHE_LQ_PACKET pkt_nxt [N];
  logic unused_req;
  assign unused_req = ^{req.addr[1:0], req.mem_func};
  // Only the first port needing a new block may talk to memory; later new-block misses retry.
  always_comb begin
    load_req_accept = '0;
    load_req_data_valid = '0;
    load_req_data = '{default: '0};
    proc2mem_command = MEM_NONE;
    proc2mem_addr = '0;
    free_any = 1'b0;
    free_idx = '0;
    tried = 1'b0;
    alloc = 1'b0;
    alloc_blk = '0;
    matched = 1'b0;
    req = '0;
    hidx = '0;
    set_mask = '{default: '0};
    hi_nxt = wait_hi;
    for (int m = NUM_MSHR - 1; m >= 0; m--)
      if (st[m] == FREE) begin
        free_any = 1'b1;
        free_idx = MW'(m);
      end
    for (int p = 0; p < NUM_LU_DCACHE; p++) begin
      req = lq_dcache_packet[p];
      hidx = req.addr[3 +: IW];
      matched = 1'b0;
      if (req.valid && !reset) begin
        if (line_v[hidx] && line_tag[hidx] == req.addr[31 -: TW]) begin
          load_req_accept[p] = 1'b1;
          load_req_data_valid[p] = 1'b1;
          load_req_data[p] = req.addr[2] ? line_data[hidx][63:32] : line_data[hidx][31:0];
        end else begin
          for (int m = 0; m < NUM_MSHR; m++)
            if (st[m] == WAIT && mblk[m] == req.addr[31:3]) begin
              matched = 1'b1;
              set_mask[m][req.lq_idx] = 1'b1;
            end
          if (matched) begin
            load_req_accept[p] = 1'b1;
            hi_nxt[req.lq_idx] = req.addr[2];
          end else if (!tried && free_any) begin
            tried = 1'b1;
            proc2mem_command = MEM_LOAD;
            proc2mem_addr = {req.addr[31:3], 3'b000};
            if (mem2proc_transaction_tag != '0) begin
              load_req_accept[p] = 1'b1;
              alloc = 1'b1;
              alloc_blk = req.addr[31:3];
              set_mask[free_idx][req.lq_idx] = 1'b1;
              hi_nxt[req.lq_idx] = req.addr[2];
            end
          end
        end
      end
    end
  end
  always_comb begin
    clr = '{default: '0};
    pkt_nxt = '{default: '0};
    for (int k = 0; k < N; k++)
      for (int m = 0; m < NUM_MSHR; m++)
        for (int l = 0; l < LQ_SIZE; l++)
          if (st[m] == DONE && wait_mask[m][l] && !clr[m][l] && !pkt_nxt[k].valid) begin
            pkt_nxt[k] = '{valid: 1'b1, lq_idx: LQ_IDX_W'(l),
                           data: wait_hi[l] ? mdata[m][63:32] : mdata[m][31:0]};
            clr[m][l] = 1'b1;
          end
  end
  always_comb begin
    st_nxt = st;
    fill = '0;
    mask_nxt = wait_mask;
    for (int m = 0; m < NUM_MSHR; m++) begin
      fill[m] = st[m] == WAIT && mem2proc_data_tag != '0 && mtag[m] == mem2proc_data_tag;
      mask_nxt[m] = (wait_mask[m] & ~clr[m]) | set_mask[m];
      st_nxt[m] = fill[m] ? DONE : (st[m] == DONE && mask_nxt[m] == '0) ? FREE : st[m];
    end
    if (alloc) st_nxt[free_idx] = WAIT;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= '{default: FREE};
      wait_mask <= '{default: '0};
      line_v <= '0;
      dcache_lq_packet <= '{default: '0};
    end else begin
      st <= st_nxt;
      wait_mask <= mask_nxt;
      dcache_lq_packet <= pkt_nxt;
      for (int m = 0; m < NUM_MSHR; m++)
        if (fill[m]) begin
          mdata[m] <= mem2proc_data;
          line_v[mblk[m][IW-1:0]] <= 1'b1;
          line_tag[mblk[m][IW-1:0]] <= mblk[m][28 -: TW];
          line_data[mblk[m][IW-1:0]] <= mem2proc_data;
        end
      if (alloc) begin
        mtag[free_idx] <= mem2proc_transaction_tag;
        mblk[free_idx] <= alloc_blk;
      end
    end
    wait_hi <= hi_nxt;
  end
endmodule

// File: tb/tb_dcache_load_responder.sv
// tb_dcache_load_responder: directed stimulus with a completion scoreboard for dcache_load_responder
module tb_dcache_load_responder;
  import dcache_load_responder_pkg::*;
  localparam int P = 2;
  localparam int N = 2;
  typedef struct {
    int lq;
    logic [31:0] data;
    int cyc;
  } exp_t;
  logic clock = 1'b0;
  logic reset;
  LQ_DCACHE_PACKET req [P];
  logic [P-1:0] acc, dv;
  DATA rdata [P];
  DCACHE_LQ_PACKET pkt [N];
  MEM_COMMAND cmd;
  ADDR maddr;
  logic [3:0] mtt, mdt;
  logic [63:0] mdata;
  exp_t sbq [$];
  exp_t mon_e;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int tags [4] = '{1, 2, 4, 6};
  dcache_load_responder dut (
    .clock(clock),
    .reset(reset),
    .lq_dcache_packet(req),
    .load_req_accept(acc),
    .load_req_data_valid(dv),
    .load_req_data(rdata),
    .dcache_lq_packet(pkt),
    .proc2mem_command(cmd),
    .proc2mem_addr(maddr),
    .mem2proc_transaction_tag(mtt),
    .mem2proc_data(mdata),
    .mem2proc_data_tag(mdt)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    for (int p = 0; p < P; p++) req[p] = '0;
    mtt = '0;
    mdt = '0;
    mdata = '0;
  endtask
  task automatic ld(int p, int lq, logic [31:0] a);
    req[p] = '{valid: 1'b1, lq_idx: LQ_IDX_W'(lq), addr: a, mem_func: 3'd2};
  endtask
  task automatic push(int lq, logic [31:0] d, int c);
    sbq.push_back('{lq, d, c});
  endtask
  // Every valid completion lane must match the oldest expected entry, in lane order.
  always @(negedge clock)
    if (!reset)
      for (int k = 0; k < N; k++)
        if (pkt[k].valid) begin
          chk("pkt_expected", 64'(sbq.size() > 0), 1);
          if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("pkt_lq", 64'(pkt[k].lq_idx), 64'(mon_e.lq));
            chk("pkt_data", 64'(pkt[k].data), 64'(mon_e.data));
            chk("pkt_cycle", 64'(cyc), 64'(mon_e.cyc));
          end
        end
  initial begin
    idle();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_accept", 64'(acc), 0);
    chk("rst_data_valid", 64'(dv), 0);
    chk("rst_data0", 64'(rdata[0]), 0);
    chk("rst_cmd", 64'(cmd), 64'(MEM_NONE));
    chk("rst_addr", 64'(maddr), 0);
    chk("rst_pkt_valid", 64'({pkt[1].valid, pkt[0].valid}), 0);
    step(); idle(); ld(0, 1, 32'h1004); mtt = 4'd3; #1;
    chk("miss_accept", 64'(acc), 2'b01);
    chk("miss_data_valid", 64'(dv), 0);
    chk("miss_cmd", 64'(cmd), 64'(MEM_LOAD));
    chk("miss_addr", 64'(maddr), 32'h1000);
    step(); idle(); ld(0, 2, 32'h1000); mtt = 4'd7; #1;
    chk("merge_accept", 64'(acc), 2'b01);
    chk("merge_cmd", 64'(cmd), 64'(MEM_NONE));
    step(); idle(); ld(0, 3, 32'h1000); mdt = 4'd3; mdata = 64'h11223344_55667788; #1;
    chk("merge_fill_accept", 64'(acc), 2'b01);
    chk("merge_fill_dv", 64'(dv), 0);
    push(1, 32'h11223344, cyc + 2);
    push(2, 32'h55667788, cyc + 2);
    push(3, 32'h55667788, cyc + 3);
    step(); idle(); ld(0, 4, 32'h1000); ld(1, 5, 32'h1004); #1;
    chk("hit_accept", 64'(acc), 2'b11);
    chk("hit_dv", 64'(dv), 2'b11);
    chk("hit_data_lo", 64'(rdata[0]), 32'h55667788);
    chk("hit_data_hi", 64'(rdata[1]), 32'h11223344);
    chk("hit_cmd", 64'(cmd), 64'(MEM_NONE));
    step(); idle(); step(); step();
    step(); idle(); ld(0, 0, 32'h2000); mtt = 4'd0; #1;
    chk("rej_accept", 64'(acc), 0);
    chk("rej_cmd", 64'(cmd), 64'(MEM_LOAD));
    step(); ld(0, 0, 32'h2000); mtt = 4'd5; #1;
    chk("retry_accept", 64'(acc), 2'b01);
    step(); idle(); mdt = 4'd5; mdata = 64'hAAAA0000_BBBB1111;
    push(0, 32'hBBBB1111, cyc + 2);
    step(); idle(); step(); step();
    for (int i = 0; i < 4; i++) begin
      step(); idle(); ld(0, i, 32'h3000 + 32'(8 * i)); mtt = 4'(tags[i]); #1;
      chk("res_alloc_accept", 64'(acc), 2'b01);
    end
    step(); idle(); ld(0, 4, 32'h3020); mtt = 4'd8; #1;
    chk("full_accept", 64'(acc), 0);
    chk("full_cmd", 64'(cmd), 64'(MEM_NONE));
    step(); idle(); mdt = 4'd1; mdata = 64'hFFFF0000_C0DE0001;
    push(0, 32'hC0DE0001, cyc + 2);
    step(); idle();
    step(); ld(0, 4, 32'h4000); ld(1, 5, 32'h4008); mtt = 4'd9; #1;
    chk("two_new_accept", 64'(acc), 2'b01);
    chk("two_new_addr", 64'(maddr), 32'h4000);
    step(); idle(); mdt = 4'd2; mdata = 64'hFFFF0000_C0DE0002; push(1, 32'hC0DE0002, cyc + 2);
    step(); idle(); mdt = 4'd4; mdata = 64'hFFFF0000_C0DE0004; push(2, 32'hC0DE0004, cyc + 2);
    step(); idle(); mdt = 4'd6; mdata = 64'hFFFF0000_C0DE0006; push(3, 32'hC0DE0006, cyc + 2);
    step(); idle(); mdt = 4'd9; mdata = 64'hFFFF0000_C0DE0009; push(4, 32'hC0DE0009, cyc + 2);
    step(); idle(); step(); step();
    step(); idle(); ld(0, 6, 32'h5000); ld(1, 7, 32'h5004); mtt = 4'd11; #1;
    chk("same_new_accept", 64'(acc), 2'b01);
    step(); idle(); mdt = 4'd11; mdata = 64'h12345678_9ABCDEF0;
    push(6, 32'h9ABCDEF0, cyc + 2);
    step(); idle(); step(); step();
    step(); idle(); ld(0, 0, 32'h6000); mtt = 4'd12; #1;
    chk("rm_alloc_accept", 64'(acc), 2'b01);
    step(); idle(); reset = 1'b1;
    step(); reset = 1'b0; mdt = 4'd12; mdata = 64'hDEAD0000_BEEF0000;
    step(); idle();
    step(); ld(0, 1, 32'h6000); mtt = 4'd0; #1;
    chk("rm_line_invalid_dv", 64'(dv), 0);
    chk("rm_line_invalid_acc", 64'(acc), 0);
    step(); idle();
    repeat (4) step();
    chk("sb_left", 64'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
